// File: rtl/dmem_wait_ctrl_if.sv
// MEM-stage bus between the core and the data-memory wait controller.
interface dmem_wait_ctrl_if;
  logic        En;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;

  modport master (output En, MemWrite, Addr, WriteData, input ReadData, Stall);
  modport slave  (input En, MemWrite, Addr, WriteData, output ReadData, Stall);
endinterface

// File: rtl/dmem_wait_ctrl.sv
// Word-addressed data RAM behind a fixed-latency access FSM; Stall freezes the core
// until the access completes. Includes a debug read port and a sticky misalignment flag.
module dmem_wait_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  CLK,
  input  logic                  Reset,
  dmem_wait_ctrl_if.slave       bus,
  output logic                  MisalignErr,
  output logic [15:0]           AccessCnt,
  input  logic [ADDR_WIDTH-1:0] DispAddr,
  output logic [31:0]           DispData
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  aligned;
  logic                  complete;
  logic                  startWait;
  logic                  stallWait;
  logic                  unusedAddrBits;

  // Upper address bits alias onto the RAM.
  assign idx            = bus.Addr[ADDR_WIDTH+1:2];
  assign aligned        = (bus.Addr[1:0] == 2'b00);
  assign unusedAddrBits = ^bus.Addr[31:ADDR_WIDTH+2];

  always_comb begin
    complete  = 1'b0;
    startWait = 1'b0;
    stallWait = 1'b0;
    if (!Reset && bus.En) begin
      case (state)
        IDLE: begin
          if (aligned) begin
            if (WAIT_STATES == 0) complete  = 1'b1;
            else                  startWait = 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) complete  = 1'b1;
          else             stallWait = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Stall    = startWait | stallWait;
  assign bus.ReadData = (complete && !bus.MemWrite) ? mem[idx] : 32'd0;
  assign DispData     = mem[DispAddr];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      MisalignErr <= 1'b0;
      AccessCnt   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.En) begin
            if (!aligned) begin
              MisalignErr <= 1'b1;
            end else if (startWait) begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          // Dropping En mid-access is a pipeline flush: abandon without writing.
          if (!bus.En)           state <= IDLE;
          else if (cnt != 4'd0)  cnt   <= cnt - 4'd1;
          else                   state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (complete && AccessCnt != 16'hFFFF) AccessCnt <= AccessCnt + 16'd1;
    end
  end

  // RAM is never reset; complete is already gated by Reset.
  always_ff @(posedge CLK) begin
    if (complete && bus.MemWrite) mem[idx] <= bus.WriteData;
  end
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Bench for dmem_wait_ctrl: transaction scoreboard on a WAIT_STATES=2 instance plus
// directed zero-wait-state accesses on a second instance.
module tb_dmem_wait_ctrl;
  localparam int AW = 8;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  dmem_wait_ctrl_if busA ();
  dmem_wait_ctrl_if busB ();
  logic          misA, misB;
  logic [15:0]   cntA, cntB;
  logic [AW-1:0] dispA, dispB;
  logic [31:0]   dDA, dDB;

  dmem_wait_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) uA (
    .CLK(CLK), .Reset(Reset), .bus(busA.slave), .MisalignErr(misA),
    .AccessCnt(cntA), .DispAddr(dispA), .DispData(dDA));

  dmem_wait_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) uB (
    .CLK(CLK), .Reset(Reset), .bus(busB.slave), .MisalignErr(misB),
    .AccessCnt(cntB), .DispAddr(dispB), .DispData(dDB));

  typedef struct {
    logic [31:0] rd;
    int          stalls;
    logic [15:0] cnt;
    logic        mis;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] memA [256];
  logic [31:0] memB [256];
  int          mCnt = 0;
  logic        mMis = 1'b0;
  int          bCnt = 0;
  int          passed = 0;
  int          total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: any cycle with En high and Stall low is a response from the DUT.
  initial begin
    int   lat;
    exp_t e;
    lat = 0;
    forever begin
      @(negedge CLK);
      if (Reset || !busA.En) begin
        check("idle stall", {31'd0, busA.Stall}, 32'd0);
        check("idle rdata", busA.ReadData, 32'd0);
        lat = 0;
      end else if (busA.Stall) begin
        check("stall rdata", busA.ReadData, 32'd0);
        lat++;
      end else begin
        if (sbq.size() == 0) begin
          total++;
          $display("FAIL unexpected response: rdata %h with empty queue", busA.ReadData);
        end else begin
          e = sbq.pop_front();
          check("rdata", busA.ReadData, e.rd);
          check("latency", 32'(lat), 32'(e.stalls));
          check("accesscnt", {16'd0, cntA}, {16'd0, e.cnt});
          check("misflag", {31'd0, misA}, {31'd0, e.mis});
        end
        lat = 0;
      end
    end
  end

  task automatic txA(input logic we, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   w;
    bit   done;
    w     = int'(addr[AW+1:2]);
    e.cnt = 16'(mCnt);
    e.mis = mMis;
    if (addr[1:0] != 2'b00) begin
      e.rd = 32'd0; e.stalls = 0; mMis = 1'b1;
    end else begin
      e.rd = we ? 32'd0 : memA[w];
      e.stalls = 2;
      if (we) memA[w] = data;
      mCnt++;
    end
    sbq.push_back(e);
    busA.En = 1'b1; busA.MemWrite = we; busA.Addr = addr; busA.WriteData = data;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge CLK);
      if (!busA.Stall) done = 1'b1;
      @(posedge CLK); #1;
    end
    if (!done) begin
      total++;
      $display("FAIL access timeout: addr %h still stalled after 20 cycles", addr);
    end
  endtask

  task automatic abortA(input logic we, input logic [31:0] addr);
    busA.En = 1'b1; busA.MemWrite = we; busA.Addr = addr; busA.WriteData = $urandom();
    @(posedge CLK); #1;
    busA.En = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic txB(input logic we, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] expRd;
    int          w;
    w = int'(addr[AW+1:2]);
    expRd = (!we && addr[1:0] == 2'b00) ? memB[w] : 32'd0;
    busB.En = 1'b1; busB.MemWrite = we; busB.Addr = addr; busB.WriteData = data;
    @(negedge CLK);
    check("B stall", {31'd0, busB.Stall}, 32'd0);
    check("B rdata", busB.ReadData, expRd);
    @(posedge CLK); #1;
    if (addr[1:0] == 2'b00) begin
      if (we) memB[w] = data;
      bCnt++;
    end
    busB.En = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    int          gap;
    busA.En = 1'b1; busA.MemWrite = 1'b1; busA.Addr = 32'h10; busA.WriteData = 32'h5555AAAA;
    busB.En = 1'b0; busB.MemWrite = 1'b0; busB.Addr = 32'd0;  busB.WriteData = 32'd0;
    dispA = '0; dispB = '0;
    Reset = 1'b1;

    // Reset holds outputs quiet even with a request pending.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset stall", {31'd0, busA.Stall}, 32'd0);
    check("reset rdata", busA.ReadData, 32'd0);
    check("reset misflag", {31'd0, misA}, 32'd0);
    check("reset accesscnt", {16'd0, cntA}, 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b0; busA.En = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 256; i++) txA(1'b1, 32'(i) << 2, $urandom());
    busA.En = 1'b0;
    @(posedge CLK); #1;

    txA(1'b1, 32'h10, 32'hDEADBEEF);
    busA.En = 1'b0; dispA = 8'd4;
    @(negedge CLK);
    check("debug after store", dDA, 32'hDEADBEEF);
    check("count after store", {16'd0, cntA}, 32'(mCnt));
    @(posedge CLK); #1;
    txA(1'b0, 32'h10, 32'd0);
    txA(1'b1, 32'h0, 32'h1);
    txA(1'b0, 32'h0, 32'd0);
    busA.En = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 15);
      a = $urandom();
      a[1:0] = (r == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (r == 1) abortA(1'($urandom()), a);
      else        txA(1'($urandom()), a, $urandom());
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        busA.En = 1'b0;
        repeat (gap) @(posedge CLK);
        #1;
      end
    end

    txA(1'b0, 32'h13, 32'd0);
    for (int i = 0; i < 5; i++) txA(1'($urandom()), $urandom() & 32'hFFFFFFFC, $urandom());
    busA.En = 1'b0;
    @(negedge CLK);
    check("misflag sticky", {31'd0, misA}, 32'd1);
    @(posedge CLK); #1;

    // Reset lands in the second stall cycle of a store.
    busA.En = 1'b1; busA.MemWrite = 1'b1; busA.Addr = 32'h20; busA.WriteData = ~memA[8];
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(negedge CLK);
    check("stall in reset cycle", {31'd0, busA.Stall}, 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b0; busA.En = 1'b0; dispA = 8'd8;
    mCnt = 0; mMis = 1'b0;
    @(negedge CLK);
    check("ram kept on reset", dDA, memA[8]);
    check("count cleared", {16'd0, cntA}, 32'd0);
    check("misflag cleared", {31'd0, misA}, 32'd0);
    @(posedge CLK); #1;
    for (int i = 0; i < 8; i++) txA(1'($urandom()), $urandom() & 32'hFFFFFFFC, $urandom());
    busA.En = 1'b0;
    @(posedge CLK); #1;

    // Zero wait states: store at 0x400 aliases word 0.
    txB(1'b1, 32'h400, 32'hCAFE0001);
    dispB = 8'd0;
    @(negedge CLK);
    check("B alias debug", dDB, 32'hCAFE0001);
    @(posedge CLK); #1;
    for (int i = 1; i < 16; i++) txB(1'b1, ($urandom() & 32'hFFFFFC00) | (32'(i) << 2), $urandom());
    for (int i = 0; i < 20; i++) begin
      a = ($urandom() & 32'hFFFFFC00) | (32'($urandom_range(0, 15)) << 2);
      txB(1'($urandom()), a, $urandom());
    end
    check("B misflag before", {31'd0, misB}, 32'd0);
    txB(1'b1, 32'h402, 32'h12345678);
    @(negedge CLK);
    check("B misflag", {31'd0, misB}, 32'd1);
    check("B accesscnt", {16'd0, cntB}, 32'(bCnt));
    dispB = 8'd0;
    #1;
    check("B word0 after misaligned", dDB, memB[0]);

    @(posedge CLK); #1;
    @(negedge CLK);
    check("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
